// File: rtl/pwm_duty_seq.sv
// pwm_duty_seq: table-driven compare-set sequencer stepping on PWM period boundaries
module pwm_duty_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int CHNL = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wr_en_i,
  input  logic [AW-1:0]              wr_addr_i,
  input  logic [CHNL*DATA_WIDTH-1:0] wr_cmp_i,
  input  logic [DATA_WIDTH-1:0]      wr_rpt_i,
  input  logic [AW:0]                len_i,
  input  logic                       loop_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       period_end_i,
  output logic [CHNL*DATA_WIDTH-1:0] cmp_o,
  output logic                       cmp_upd_o,
  output logic [AW-1:0]              idx_o,
  output logic                       busy_o,
  output logic                       done_o
);
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state;
  logic [CHNL*DATA_WIDTH-1:0] tbl_cmp [DEPTH];
  logic [DATA_WIDTH-1:0] tbl_rpt [DEPTH];
  logic [DATA_WIDTH-1:0] rpt_cnt;
  logic [AW:0] len_q;
  logic loop_q, last, ld;
  logic [AW-1:0] ld_idx;
  always_comb begin
    last = {1'b0, idx_o} == len_q - (AW+1)'(1);
    ld_idx = (state == ARM || last) ? '0 : idx_o + AW'(1);
    ld = !stop_i && period_end_i &&
         (state == ARM || (state == RUN && rpt_cnt == '0 && (!last || loop_q)));
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cmp_o <= '0;
      cmp_upd_o <= 1'b0;
      idx_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      rpt_cnt <= '0;
      len_q <= '0;
      loop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_cmp[i] <= '0;
        tbl_rpt[i] <= '0;
      end
    end else begin
      if (wr_en_i) begin
        tbl_cmp[wr_addr_i] <= wr_cmp_i;
        tbl_rpt[wr_addr_i] <= wr_rpt_i;
      end
      cmp_upd_o <= ld;
      done_o <= 1'b0;
      if (ld) begin
        cmp_o <= tbl_cmp[ld_idx];
        rpt_cnt <= tbl_rpt[ld_idx];
        idx_o <= ld_idx;
      end
      if (stop_i) begin
        state <= IDLE;
        busy_o <= 1'b0;
      end else if (state == IDLE && start_i) begin
        if (len_i == '0) begin
          done_o <= 1'b1;
        end else begin
          len_q <= (len_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len_i;
          loop_q <= loop_i;
          state <= ARM;
          busy_o <= 1'b1;
        end
      end else if (period_end_i && state == ARM) begin
        state <= RUN;
      end else if (period_end_i && state == RUN && rpt_cnt != '0) begin
        rpt_cnt <= rpt_cnt - DATA_WIDTH'(1);
      end else if (period_end_i && state == RUN && last && !loop_q) begin
        state <= IDLE;
        busy_o <= 1'b0;
        done_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_seq.sv
// tb_pwm_duty_seq: directed and random sequences checked against a flattened per-period schedule model
module tb_pwm_duty_seq;
  localparam int DW = 16;
  localparam int CH = 4;
  localparam int DP = 8;
  localparam int AW = 3;
  localparam int CW = CH*DW;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic wr_en_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [CW-1:0] wr_cmp_i = '0;
  logic [DW-1:0] wr_rpt_i = '0;
  logic [AW:0] len_i = '0;
  logic loop_i = 1'b0;
  logic start_i = 1'b0;
  logic stop_i = 1'b0;
  logic period_end_i = 1'b0;
  logic [CW-1:0] cmp_o;
  logic cmp_upd_o;
  logic [AW-1:0] idx_o;
  logic busy_o;
  logic done_o;
  logic [CW-1:0] mcmp [DP];
  logic [DW-1:0] mrpt [DP];
  logic [CW-1:0] gcmp;
  logic [AW-1:0] gidx;
  int n_chk = 0;
  int n_fail = 0;

  pwm_duty_seq dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_cmp_i(wr_cmp_i), .wr_rpt_i(wr_rpt_i), .len_i(len_i), .loop_i(loop_i),
    .start_i(start_i), .stop_i(stop_i), .period_end_i(period_end_i), .cmp_o(cmp_o),
    .cmp_upd_o(cmp_upd_o), .idx_o(idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit upd, input bit done, input bit busy);
    chk({tag, ".upd"}, CW'(cmp_upd_o), CW'(upd));
    chk({tag, ".done"}, CW'(done_o), CW'(done));
    chk({tag, ".busy"}, CW'(busy_o), CW'(busy));
    chk({tag, ".idx"}, CW'(idx_o), CW'(gidx));
    chk({tag, ".cmp"}, cmp_o, gcmp);
  endtask

  task automatic wr(input int a, input logic [CW-1:0] c, input logic [DW-1:0] r);
    wr_en_i = 1'b1;
    wr_addr_i = AW'(a);
    wr_cmp_i = c;
    wr_rpt_i = r;
    tick();
    wr_en_i = 1'b0;
    mcmp[a] = c;
    mrpt[a] = r;
  endtask

  // Expected behaviour: the active entries expanded into one slot per PWM period,
  // with a flag marking the first period of each application of an entry.
  task automatic run_seq(input int len, input bit lp, input int npe, input bit pe_s,
                         input bit restart, input bit coll, input logic [CW-1:0] coll_val);
    int slot_e[$];
    bit slot_s[$];
    int l, s;
    bit mbusy;
    len_i = (AW+1)'(len);
    loop_i = lp;
    start_i = 1'b1;
    period_end_i = pe_s;
    tick();
    start_i = 1'b0;
    period_end_i = 1'b0;
    if (len == 0) begin
      chk_all("len0_start", 0, 1, 0);
      tick();
      chk_all("len0_after", 0, 0, 0);
      return;
    end
    chk_all("armed", 0, 0, 1);
    mbusy = 1'b1;
    l = len > DP ? DP : len;
    for (int e = 0; e < l; e++)
      for (int r = 0; r <= int'(mrpt[e]); r++) begin
        slot_e.push_back(e);
        slot_s.push_back(r == 0);
      end
    for (int k = 0; k < npe; k++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk_all("idle", 0, 0, mbusy);
      end
      if (restart && k == 1) begin
        len_i = (AW+1)'(1);
        loop_i = ~lp;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk_all("restart", 0, 0, mbusy);
      end
      period_end_i = 1'b1;
      if (coll && k == 1) begin
        wr_en_i = 1'b1;
        wr_addr_i = AW'(1);
        wr_cmp_i = coll_val;
        wr_rpt_i = mrpt[1];
      end
      tick();
      period_end_i = 1'b0;
      wr_en_i = 1'b0;
      if (!mbusy) begin
        chk_all("pe_idle", 0, 0, 0);
      end else if (!lp && k == slot_e.size()) begin
        mbusy = 1'b0;
        chk_all("finish", 0, 1, 0);
      end else begin
        s = k % slot_e.size();
        if (slot_s[s]) begin
          gidx = AW'(slot_e[s]);
          gcmp = mcmp[slot_e[s]];
        end
        chk_all("period", slot_s[s], 0, 1);
      end
      if (coll && k == 1) mcmp[1] = coll_val;
    end
    if (mbusy) begin
      stop_i = 1'b1;
      period_end_i = 1'b1;
      tick();
      stop_i = 1'b0;
      period_end_i = 1'b0;
      chk_all("stop", 0, 0, 0);
    end
    tick();
    chk_all("settled", 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < DP; i++) begin
      mcmp[i] = '0;
      mrpt[i] = '0;
    end
    gcmp = '0;
    gidx = '0;
    rst_n_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      wr_en_i = ~wr_en_i;
      start_i = ~start_i;
      wr_addr_i = AW'($urandom);
      wr_cmp_i = {$urandom, $urandom};
      wr_rpt_i = DW'($urandom);
      len_i = (AW+1)'(3);
      period_end_i = ~period_end_i;
    end
    @(negedge clk_i);
    wr_en_i = 1'b0;
    start_i = 1'b0;
    period_end_i = 1'b0;
    rst_n_i = 1'b1;
    tick();
    chk_all("reset", 0, 0, 0);
    run_seq(DP, 0, DP + 1, 0, 0, 0, '0);
    wr(0, CW'(10), 0);
    wr(1, CW'(20), 0);
    wr(2, CW'(30), 0);
    run_seq(3, 0, 4, 0, 0, 0, '0);
    wr(0, CW'(64'h1111_2222_3333_0044), 2);
    wr(1, CW'(64'h5555_6666_7777_0088), 0);
    run_seq(2, 1, 8, 0, 0, 0, '0);
    run_seq(0, 0, 0, 0, 0, 0, '0);
    run_seq(2, 0, 5, 1, 1, 0, '0);
    wr(0, CW'(64'hA), 0);
    wr(1, CW'(64'hB), 0);
    run_seq(2, 1, 5, 0, 0, 1, CW'(64'hBEEF));
    for (int it = 0; it < 12; it++) begin
      for (int e = 0; e < DP; e++) wr(e, {$urandom, $urandom}, DW'($urandom_range(0, 3)));
      run_seq($urandom_range(0, DP + 3), 1'($urandom), $urandom_range(2, 20),
              1'($urandom), 1'($urandom), 0, '0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
